// File: rtl/lms_wb_sequencer.sv
// Wishbone master that streams samples through a wb_lms peripheral: writes x/d, reads y/err,
// and switches MODE from training to filtering after train_len samples.
module lms_wb_sequencer #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DW          = 16,
   parameter int          ACK_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [15:0]   train_len,
   input  logic [15:0]   run_len,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_x,
   input  logic [DW-1:0] s_d,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_y,
   output logic [DW-1:0] m_err,
   output logic [15:0]   m_idx,
   output logic          m_train,
   output logic          wbm_cyc_o,
   output logic          wbm_stb_o,
   output logic          wbm_we_o,
   output logic [31:0]   wbm_adr_o,
   output logic [DW-1:0] wbm_dat_o,
   input  logic [DW-1:0] wbm_dat_i,
   input  logic          wbm_ack_i,
   output logic          busy,
   output logic          done,
   output logic          timeout
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE, SET_MODE, GET, WR_X, WR_D, RD_Y, RD_E, EMIT, FINISH
   } state_t;

   state_t         state_reg, state_next;
   logic           cyc_reg, cyc_next;
   logic           we_reg, we_next;
   logic [31:0]    adr_reg, adr_next;
   logic [DW-1:0]  dat_reg, dat_next;
   logic           gap_reg, gap_next;
   logic [TW-1:0]  tmo_reg, tmo_next;
   logic           mode_reg, mode_next;
   logic [15:0]    idx_reg, idx_next;
   logic [15:0]    train_len_reg, train_len_next;
   logic [15:0]    run_len_reg, run_len_next;
   logic [DW-1:0]  x_reg, x_next, d_reg, d_next;
   logic [DW-1:0]  y_reg, y_next, err_reg, err_next;
   logic           busy_reg, busy_next;
   logic           done_reg, done_next;
   logic           timeout_reg, timeout_next;
   logic [15:0]    idx_inc;
   logic           acked;

   always_comb begin
      state_next     = state_reg;
      cyc_next       = cyc_reg;
      we_next        = we_reg;
      adr_next       = adr_reg;
      dat_next       = dat_reg;
      gap_next       = gap_reg;
      tmo_next       = tmo_reg;
      mode_next      = mode_reg;
      idx_next       = idx_reg;
      train_len_next = train_len_reg;
      run_len_next   = run_len_reg;
      x_next         = x_reg;
      d_next         = d_reg;
      y_next         = y_reg;
      err_next       = err_reg;
      busy_next      = busy_reg;
      done_next      = 1'b0;
      timeout_next   = timeout_reg;
      idx_inc        = idx_reg + 16'd1;
      acked          = cyc_reg & wbm_ack_i;

      case (state_reg)
         IDLE: begin
            if (start) begin
               train_len_next = train_len;
               run_len_next   = run_len;
               idx_next       = 16'd0;
               busy_next      = 1'b1;
               timeout_next   = 1'b0;
               mode_next      = (train_len != 16'd0);
               state_next     = SET_MODE;
            end
         end
         GET: begin
            if (abort) begin
               state_next = FINISH;
            end else if (s_valid) begin
               x_next     = s_x;
               d_next     = s_d;
               state_next = WR_X;
            end
         end
         EMIT: begin
            if (m_ready) begin
               idx_next = idx_inc;
               if (abort || (run_len_reg != 16'd0 && idx_inc == run_len_reg)) begin
                  state_next = FINISH;
               end else if (mode_reg && idx_inc == train_len_reg) begin
                  mode_next  = 1'b0;
                  state_next = SET_MODE;
               end else begin
                  state_next = GET;
               end
            end
         end
         FINISH: state_next = IDLE;
         SET_MODE, WR_X, WR_D, RD_Y, RD_E: begin
            // Each bus state is an active phase (stb high) followed by one idle gap cycle.
            if (!gap_reg) begin
               if (acked) begin
                  cyc_next = 1'b0;
                  gap_next = 1'b1;
                  if (state_reg == RD_Y) y_next = wbm_dat_i;
                  if (state_reg == RD_E) err_next = wbm_dat_i;
               end else if (tmo_reg == TMO_LAST) begin
                  cyc_next     = 1'b0;
                  timeout_next = 1'b1;
                  done_next    = 1'b1;
                  busy_next    = 1'b0;
                  state_next   = IDLE;
               end else begin
                  tmo_next = tmo_reg + TW'(1);
               end
            end else begin
               case (state_reg)
                  SET_MODE: state_next = GET;
                  WR_X:     state_next = WR_D;
                  WR_D:     state_next = RD_Y;
                  RD_Y:     state_next = RD_E;
                  default:  state_next = EMIT;
               endcase
            end
         end
         default: state_next = IDLE;
      endcase

      if (state_next == FINISH && state_reg != FINISH) begin
         done_next = 1'b1;
         busy_next = 1'b0;
      end

      // Bus strobes and payload are launched on entry so they are registered and stable.
      if (state_next != state_reg) begin
         gap_next = 1'b0;
         tmo_next = '0;
         case (state_next)
            SET_MODE: begin
               cyc_next = 1'b1;
               we_next  = 1'b1;
               adr_next = BASE_ADDR + 32'h08;
               dat_next = {{(DW-1){1'b0}}, mode_next};
            end
            WR_X: begin
               cyc_next = 1'b1;
               we_next  = 1'b1;
               adr_next = BASE_ADDR;
               dat_next = x_next;
            end
            WR_D: begin
               cyc_next = 1'b1;
               we_next  = 1'b1;
               adr_next = BASE_ADDR + 32'h04;
               dat_next = mode_reg ? d_reg : '0;
            end
            RD_Y: begin
               cyc_next = 1'b1;
               we_next  = 1'b0;
               adr_next = BASE_ADDR + 32'h0C;
               dat_next = '0;
            end
            RD_E: begin
               cyc_next = 1'b1;
               we_next  = 1'b0;
               adr_next = BASE_ADDR + 32'h10;
               dat_next = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cyc_reg       <= 1'b0;
         we_reg        <= 1'b0;
         adr_reg       <= '0;
         dat_reg       <= '0;
         gap_reg       <= 1'b0;
         tmo_reg       <= '0;
         mode_reg      <= 1'b0;
         idx_reg       <= '0;
         train_len_reg <= '0;
         run_len_reg   <= '0;
         x_reg         <= '0;
         d_reg         <= '0;
         y_reg         <= '0;
         err_reg       <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         timeout_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cyc_reg       <= cyc_next;
         we_reg        <= we_next;
         adr_reg       <= adr_next;
         dat_reg       <= dat_next;
         gap_reg       <= gap_next;
         tmo_reg       <= tmo_next;
         mode_reg      <= mode_next;
         idx_reg       <= idx_next;
         train_len_reg <= train_len_next;
         run_len_reg   <= run_len_next;
         x_reg         <= x_next;
         d_reg         <= d_next;
         y_reg         <= y_next;
         err_reg       <= err_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         timeout_reg   <= timeout_next;
      end
   end

   assign s_ready   = (state_reg == GET) & ~abort;
   assign m_valid   = (state_reg == EMIT);
   assign m_y       = y_reg;
   assign m_err     = err_reg;
   assign m_idx     = idx_reg;
   assign m_train   = mode_reg;
   assign wbm_cyc_o = cyc_reg;
   assign wbm_stb_o = cyc_reg;
   assign wbm_we_o  = we_reg;
   assign wbm_adr_o = adr_reg;
   assign wbm_dat_o = dat_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign timeout   = timeout_reg;
endmodule

// File: tb/tb_lms_wb_sequencer.sv
// Bench for lms_wb_sequencer: fake wb_lms slave (y = x/2, err = d - y) and a sample-level
// reference model of what each run should emit and write.
module tb_lms_wb_sequencer;
   logic        clk = 1'b0, rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
   logic [15:0] train_len = '0, run_len = '0, s_x = '0, s_d = '0;
   logic        s_ready, m_valid, m_train, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
   logic        busy, done, timeout;
   logic [15:0] m_y, m_err, m_idx, wbm_dat_o, wbm_dat_i;
   logic [31:0] wbm_adr_o;
   int          checks = 0, errors = 0;

   lms_wb_sequencer #(.BASE_ADDR(32'h0), .DW(16), .ACK_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .train_len(train_len), .run_len(run_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
      .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_err(m_err),
      .m_idx(m_idx), .m_train(m_train),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i), .busy(busy), .done(done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Slave model: combinational ack, optional delay on 0x0C, optional never-ack on 0x00.
   logic [15:0] sl_x = '0, sl_d = '0, sl_y;
   int          wait_cnt = 0, dly_y = 1;
   bit          noack_x = 1'b0, spur = 1'b0;
   logic [23:0] wr_q[$];

   always_comb sl_y = {sl_x[15], sl_x[15:1]};
   always_comb begin
      wbm_dat_i = 16'h0000;
      if (wbm_adr_o[7:0] == 8'h0C) wbm_dat_i = sl_y;
      else if (wbm_adr_o[7:0] == 8'h10) wbm_dat_i = sl_d - sl_y;
   end
   always_comb begin
      wbm_ack_i = spur;
      if (wbm_cyc_o && wbm_stb_o) begin
         if (noack_x && wbm_adr_o[7:0] == 8'h00) wbm_ack_i = 1'b0;
         else if (wbm_adr_o[7:0] == 8'h0C) wbm_ack_i = (wait_cnt + 1 >= dly_y);
         else wbm_ack_i = 1'b1;
      end
   end
   always @(posedge clk) begin
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o) begin
         wr_q.push_back({wbm_adr_o[7:0], wbm_dat_o});
         if (wbm_adr_o[7:0] == 8'h00) sl_x <= wbm_dat_o;
         if (wbm_adr_o[7:0] == 8'h04) sl_d <= wbm_dat_o;
      end
   end

   // Bus monitor: access lengths, addresses, idle gaps and mid-access payload changes.
   logic [7:0]  adr_q[$];
   int          len_q[$], gap_q[$];
   int          cur_len = 0, gap_len = 0, unstable = 0;
   logic [31:0] cur_adr = '0;
   logic [15:0] cur_dat = '0;
   logic        cur_we = 1'b0, prev_stb = 1'b0;
   always @(negedge clk) begin
      if (wbm_cyc_o != wbm_stb_o) unstable <= unstable + 1;
      if (wbm_stb_o) begin
         if (!prev_stb) begin
            cur_len <= 1;
            cur_adr <= wbm_adr_o;
            cur_dat <= wbm_dat_o;
            cur_we  <= wbm_we_o;
            gap_q.push_back(gap_len);
         end else begin
            cur_len <= cur_len + 1;
            if (wbm_adr_o != cur_adr || wbm_dat_o != cur_dat || wbm_we_o != cur_we)
               unstable <= unstable + 1;
         end
      end else if (prev_stb) begin
         len_q.push_back(cur_len);
         adr_q.push_back(cur_adr[7:0]);
         gap_len <= 1;
      end else begin
         gap_len <= gap_len + 1;
      end
      prev_stb <= wbm_stb_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_y(input logic [15:0] x);
      return $signed(x) >>> 1;
   endfunction

   bit          fix_en = 1'b0;
   logic [15:0] fix_x = '0, fix_d = '0, last_y = '0, last_err = '0;

   task automatic run_session(input string tag, input logic [15:0] tl, input logic [15:0] rl,
                              input int n_exp, input bit exp_tmo, input bit hold_abort);
      logic [15:0] xq[$];
      logic [15:0] dq[$];
      logic [23:0] exp_tr[$];
      logic [15:0] ey, edw;
      bit          etr;
      int          got, dones, cycles;
      got = 0; dones = 0; cycles = 0;
      wr_q.delete();
      train_len = tl; run_len = rl; abort = hold_abort; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("%s busy_after_start", tag), 32'(busy), 32'd1);
      check($sformatf("%s timeout_cleared", tag), 32'(timeout), 32'd0);
      while (dones == 0 && cycles < 4000) begin
         s_valid = fix_en ? 1'b1 : ($urandom_range(0, 3) != 0);
         s_x     = fix_en ? fix_x : 16'($urandom);
         s_d     = fix_en ? fix_d : 16'($urandom);
         m_ready = ($urandom_range(0, 3) != 0);
         start   = busy && ($urandom_range(0, 7) == 0);
         if (start) begin
            train_len = 16'($urandom);
            run_len   = 16'($urandom);
         end
         @(negedge clk);
         if (s_valid && s_ready) begin
            xq.push_back(s_x);
            dq.push_back(s_d);
         end
         if (m_valid && m_ready) begin
            check($sformatf("%s emit_expected", tag), 32'(got < n_exp && got < xq.size()), 32'd1);
            if (got < xq.size()) begin
               etr = (got < int'(tl));
               edw = etr ? dq[got] : 16'h0000;
               ey  = ref_y(xq[got]);
               check($sformatf("%s y[%0d]", tag, got), 32'(m_y), 32'(ey));
               check($sformatf("%s err[%0d]", tag, got), 32'(m_err), 32'(16'(edw - ey)));
               check($sformatf("%s idx[%0d]", tag, got), 32'(m_idx), 32'(16'(got)));
               check($sformatf("%s train[%0d]", tag, got), 32'(m_train), 32'(etr));
            end
            $display("%s sample %0d x=%h y=%h err=%h train=%0d", tag, m_idx,
                     (got < xq.size()) ? xq[got] : 16'h0, m_y, m_err, m_train);
            last_y = m_y;
            last_err = m_err;
            got++;
         end
         if (done) dones++;
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; abort = 1'b0;
      check($sformatf("%s done_seen", tag), 32'(dones), 32'd1);
      check($sformatf("%s samples", tag), 32'(got), 32'(n_exp));
      check($sformatf("%s inputs", tag), 32'(xq.size()), 32'(n_exp + int'(exp_tmo)));
      check($sformatf("%s done_one_cycle", tag), 32'(done), 32'd0);
      check($sformatf("%s busy_end", tag), 32'(busy), 32'd0);
      check($sformatf("%s timeout_flag", tag), 32'(timeout), 32'(exp_tmo));
      exp_tr.push_back({8'h08, 15'h0, tl != 16'd0});
      for (int k = 0; k < n_exp; k++) begin
         if (tl != 16'd0 && k == int'(tl)) exp_tr.push_back({8'h08, 16'h0000});
         exp_tr.push_back({8'h00, xq[k]});
         exp_tr.push_back({8'h04, (k < int'(tl)) ? dq[k] : 16'h0000});
      end
      check($sformatf("%s trace_len", tag), 32'(wr_q.size()), 32'(exp_tr.size()));
      for (int i = 0; i < exp_tr.size() && i < wr_q.size(); i++)
         check($sformatf("%s trace[%0d]", tag, i), {8'h0, wr_q[i]}, {8'h0, exp_tr[i]});
   endtask

   initial begin
      int  n;
      bit  stable;
      logic [15:0] y0, e0;

      #1;
      check("reset_bus", {29'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'h0);
      check("reset_adr", wbm_adr_o, 32'h0);
      check("reset_status", {29'h0, busy, done, timeout}, 32'h0);
      check("reset_stream", {29'h0, m_valid, s_ready, m_train}, 32'h0);
      check("reset_m_data", {m_y, m_idx}, 32'h0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      run_session("A", 16'd3, 16'd5, 5, 1'b0, 1'b0);
      run_session("B", 16'd10, 16'd4, 4, 1'b0, 1'b0);

      // Filter-only single sample with a slow RD_Y ack
      dly_y = 5; fix_en = 1'b1; fix_x = 16'h1000; fix_d = 16'h1234;
      adr_q.delete(); len_q.delete(); gap_q.delete();
      run_session("C", 16'd0, 16'd1, 1, 1'b0, 1'b0);
      check("C y_value", 32'(last_y), 32'h0800);
      check("C err_value", 32'(last_err), 32'h0000_F800);
      check("C wr_d_zero", {8'h0, wr_q[2]}, 32'h0004_0000);
      check("C access_count", 32'(len_q.size()), 32'd5);
      check("C rd_y_addr", 32'(adr_q[3]), 32'h0C);
      check("C rd_y_len", 32'(len_q[3]), 32'd5);
      check("C gap_before_rd_y", 32'(gap_q[3]), 32'd1);
      check("C gap_after_rd_y", 32'(gap_q[4]), 32'd1);
      dly_y = 1; fix_en = 1'b0;

      spur = 1'b1;
      run_session("D", 16'd2, 16'd6, 6, 1'b0, 1'b0);
      spur = 1'b0;

      run_session("E", 16'd5, 16'd0, 0, 1'b0, 1'b1);

      noack_x = 1'b1;
      adr_q.delete(); len_q.delete(); gap_q.delete();
      run_session("F", 16'd0, 16'd2, 0, 1'b1, 1'b0);
      check("F access_count", 32'(len_q.size()), 32'd2);
      check("F stuck_addr", 32'(adr_q[1]), 32'h00);
      check("F stb_len", 32'(len_q[1]), 32'd64);
      check("F idle_outputs", {29'h0, wbm_stb_o, s_ready, m_valid}, 32'h0);
      noack_x = 1'b0;

      run_session("G", 16'd1, 16'd2, 2, 1'b0, 1'b0);

      // Consumer stall in EMIT, then abort
      wr_q.delete();
      train_len = 16'd0; run_len = 16'd0; s_valid = 1'b1; s_x = 16'h0246; s_d = 16'h7777;
      m_ready = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!m_valid && n < 200) begin @(negedge clk); n++; end
      check("stall m_valid", 32'(m_valid), 32'd1);
      y0 = m_y; e0 = m_err;
      check("stall y", 32'(y0), 32'(ref_y(16'h0246)));
      check("stall err", 32'(e0), 32'(16'(16'h0000 - ref_y(16'h0246))));
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!(m_valid && m_y == y0 && m_err == e0 && m_idx == 16'd0 && !wbm_stb_o && !wbm_cyc_o && !s_ready))
            stable = 1'b0;
      end
      check("stall hold", 32'(stable), 32'd1);
      @(posedge clk); #1;
      abort = 1'b1; m_ready = 1'b1;
      @(posedge clk); #1;
      check("abort done", {30'h0, done, busy}, 32'h2);
      @(posedge clk); #1;
      check("abort after", {30'h0, done, busy}, 32'h0);
      abort = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
      check("abort trace_len", 32'(wr_q.size()), 32'd3);
      check("abort trace_x", {8'h0, wr_q[1]}, 32'h0000_0246);

      // Asynchronous reset while RD_E is on the bus
      train_len = 16'd1; run_len = 16'd0; s_valid = 1'b1; m_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(wbm_stb_o && wbm_adr_o[7:0] == 8'h10) && n < 200) begin @(negedge clk); n++; end
      check("rst reach_rd_e", 32'(wbm_stb_o && wbm_adr_o[7:0] == 8'h10), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst async_bus", {30'h0, wbm_cyc_o, wbm_stb_o}, 32'h0);
      check("rst async_status", {30'h0, busy, m_valid}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      @(posedge clk); #1;
      run_session("H", 16'd1, 16'd3, 3, 1'b0, 1'b0);

      check("bus_stability", 32'(unstable), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
